// File: rtl/match_sched.sv
`default_nettype none
// ============================================================================
// Module      : match_sched
// Description : Round-robin scheduler sharing one nibble pattern-match
//               counter among four requesters. Grants one requester, primes
//               the matcher with that requester's pattern, streams its
//               nibbles, drains the matcher's hit pulses and reports the
//               per-burst hit count tagged with the requester ID.
// Ports       : clock, reset_n           - clock / async active-low reset
//               req, req_num, gnt        - requester side (4 lanes)
//               cfg_we, cfg_id, cfg_seq  - pattern register write port
//               m_valid, m_num, m_seq    - matcher stream outputs
//               m_hit                    - matcher hit pulses
//               res_valid, res_id, res_cnt - per-burst result
//               busy, err                - status (err is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module match_sched #(
  parameter int MAX_BURST     = 15,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_num,
  output logic [3:0]  gnt,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_id,
  input  logic [3:0]  cfg_seq,
  output logic        m_valid,
  output logic [3:0]  m_num,
  output logic [3:0]  m_seq,
  input  logic        m_hit,
  output logic        res_valid,
  output logic [1:0]  res_id,
  output logic [3:0]  res_cnt,
  output logic        busy,
  output logic        err
);

  localparam int c_BC_W = $clog2(MAX_BURST + 1);
  localparam int c_DC_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [c_BC_W-1:0] c_MAX_BC  = c_BC_W'(MAX_BURST);
  localparam logic [c_DC_W-1:0] c_DC_LAST = c_DC_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t              r_state;
  logic [1:0]          r_last;
  logic [1:0]          r_w;
  logic [c_BC_W-1:0]   r_bc;
  logic [c_DC_W-1:0]   r_dc;
  logic [3:0]          r_hc;
  logic                r_err;
  logic [3:0]          r_m_seq;
  logic [1:0]          r_res_id;
  logic [3:0]          r_res_cnt;
  logic [3:0]          r_pat [4];

  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic                w_found;
  logic [3:0]          w_new_seq;
  logic                w_stream_go;

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // A pattern write landing in the grant cycle must be seen by that burst.
  assign w_new_seq = (cfg_we && (cfg_id == w_win)) ? cfg_seq : r_pat[w_win];

  // Beat accepted this cycle: requester still has data and cap not reached.
  assign w_stream_go = (r_state == ST_STREAM) && req[r_w] && (r_bc < c_MAX_BC);

  assign gnt       = w_stream_go ? (4'b0001 << r_w) : 4'b0000;
  assign m_valid   = (r_state == ST_PRIME) || w_stream_go;
  assign m_num     = w_stream_go ? req_num[{r_w, 2'b00} +: 4] : 4'h0;
  assign m_seq     = r_m_seq;
  assign res_valid = (r_state == ST_REPORT);
  assign res_id    = r_res_id;
  assign res_cnt   = r_res_cnt;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_pat[i] <= 4'h0;
    end else if (cfg_we) begin
      r_pat[cfg_id] <= cfg_seq;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 2'd3;
      r_w       <= 2'd0;
      r_bc      <= '0;
      r_dc      <= '0;
      r_hc      <= 4'h0;
      r_err     <= 1'b0;
      r_m_seq   <= 4'h0;
      r_res_id  <= 2'd0;
      r_res_cnt <= 4'h0;
    end else begin
      // The matcher may only answer after the stream has ended.
      if (m_hit && ((r_state == ST_IDLE) || (r_state == ST_PRIME) ||
                    (r_state == ST_STREAM)))
        r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_w     <= w_win;
            r_last  <= w_win;
            r_m_seq <= w_new_seq;
            r_state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          r_bc    <= '0;
          r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_stream_go) begin
            r_bc <= r_bc + 1'b1;
          end else begin
            r_hc    <= 4'h0;
            r_dc    <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_hit) begin
            if (r_dc == c_DC_LAST) begin
              // Matcher never stopped: flag it and report a saturated count.
              r_err     <= 1'b1;
              r_res_cnt <= 4'hF;
              r_res_id  <= r_w;
              r_state   <= ST_REPORT;
            end else begin
              r_hc <= (r_hc == 4'hF) ? 4'hF : r_hc + 4'h1;
              r_dc <= r_dc + 1'b1;
            end
          end else begin
            r_res_cnt <= r_hc;
            r_res_id  <= r_w;
            r_state   <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          r_m_seq <= 4'h0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_match_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_sched
// Description : Scoreboard bench for match_sched. Requester front-ends and
//               the matcher's hit responder are modelled by the bench;
//               expected results are queued at issue time and checked by
//               an independent monitor on every res_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_num;
  logic [3:0]  gnt;
  logic        cfg_we;
  logic [1:0]  cfg_id;
  logic [3:0]  cfg_seq;
  logic        m_valid;
  logic [3:0]  m_num;
  logic [3:0]  m_seq;
  logic        m_hit;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [3:0]  res_cnt;
  logic        busy;
  logic        err;

  match_sched #(.MAX_BURST(15), .DRAIN_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_num(req_num),
    .gnt(gnt), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_seq(cfg_seq),
    .m_valid(m_valid), .m_num(m_num), .m_seq(m_seq), .m_hit(m_hit),
    .res_valid(res_valid), .res_id(res_id), .res_cnt(res_cnt),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int id;
    int cnt;
    int n;
    int off;   // cycles from m_valid fall (E) to res_valid
    int seq;
    int err;
    int t;     // cycle req rose in IDLE, -1 if not checked
  } exp_t;

  exp_t       sb[$];
  int         hit_q[$];
  logic [3:0] beat_q [4][$];
  int         pulse_req = 0;
  int         rep_seen  = 0;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester front-ends: req held high while nibbles remain.
  initial begin : drv
    logic [3:0] cons;
    cons    = 4'h0;
    req     = 4'h0;
    req_num = 16'h0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++)
        if (cons[i] && beat_q[i].size() > 0) void'(beat_q[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        req[i] = (beat_q[i].size() > 0);
        req_num[4*i +: 4] = req[i] ? beat_q[i][0] : 4'h0;
      end
      #1 cons = gnt & req;
    end
  end

  // Matcher hit responder: k contiguous hits starting the cycle after m_valid falls.
  initial begin : hitdrv
    int   left;
    int   seen;
    logic pv;
    left  = 0;
    seen  = 0;
    pv    = 1'b0;
    m_hit = 1'b0;
    forever begin
      @(negedge clock);
      if (left > 0) begin
        m_hit = 1'b1;
        left--;
      end else if (pulse_req != seen) begin
        m_hit = 1'b1;
        seen++;
      end else begin
        m_hit = 1'b0;
      end
      #1;
      if (pv && !m_valid) left = (hit_q.size() > 0) ? hit_q.pop_front() : 0;
      pv = m_valid;
    end
  end

  // Monitor: checks stream behaviour and pops the scoreboard on each result.
  initial begin : mon
    int   gcnt;
    int   fall_cyc;
    logic pv;
    exp_t e;
    gcnt     = 0;
    fall_cyc = 0;
    pv       = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (m_valid && gnt == 4'h0) begin
        gcnt = 0;
        if (sb.size() > 0) begin
          chk("prime_seq", m_seq, sb[0].seq);
          chk("prime_num", m_num, 0);
        end
      end
      if (gnt != 4'h0) begin
        if (sb.size() > 0) begin
          chk("gnt_id", gnt, 1 << sb[0].id);
          if (gcnt == 0 && sb[0].t >= 0) chk("first_gnt_lat", cyc, sb[0].t + 2);
          chk("m_num", m_num, req_num[4*sb[0].id +: 4]);
        end
        gcnt++;
      end
      if (pv && !m_valid) fall_cyc = cyc;
      pv = m_valid;
      if (res_valid) begin
        rep_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_res", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_cnt", res_cnt, e.cnt);
          chk("beats", gcnt, e.n);
          chk("res_lat", cyc - fall_cyc, e.off);
          chk("rep_seq", m_seq, e.seq);
          chk("rep_err", err, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // Nibbles are taken least-significant first.
  task automatic push_beats(input int id, input logic [63:0] vals, input int n);
    for (int i = 0; i < n; i++) beat_q[id].push_back(vals[4*i +: 4]);
  endtask

  task automatic expect_burst(input int id, input int cnt, input int n, input int off,
                              input int seq, input int e, input int t, input int k);
    exp_t x;
    x.id = id; x.cnt = cnt; x.n = n; x.off = off; x.seq = seq; x.err = e; x.t = t;
    sb.push_back(x);
    hit_q.push_back(k);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    chk(name, sb.size(), 0);
    sb.delete();
    tick();
    tick();
  endtask

  task automatic cfg_write(input int id, input int val);
    cfg_we  = 1'b1;
    cfg_id  = 2'(id);
    cfg_seq = 4'(val);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin : main
    int t;
    int base;
    cfg_we  = 1'b0;
    cfg_id  = 2'd0;
    cfg_seq = 4'h0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {gnt, m_valid, m_num, m_seq, res_valid, res_id, res_cnt, busy, err}, 0);
    reset_n = 1'b1;
    tick();

    // Basic burst: pattern 5, stream 5,3,5,5, three hits -> report at E+5.
    cfg_write(0, 5);
    t = cyc;
    push_beats(0, 64'h5535, 4);
    expect_burst(0, 3, 4, 5, 5, 0, t, 3);
    wait_done("basic_done", 60);
    tick();
    chk("res_hold_cnt", res_cnt, 3);
    chk("idle_busy", busy, 0);

    // Round robin from reset: 0,1,2,3 then 0 again.
    do_reset();
    t = cyc;
    base = rep_seen;
    for (int i = 0; i < 4; i++) push_beats(i, 64'h21, 2);
    expect_burst(0, 1, 2, 3, 0, 0, t, 1);
    expect_burst(1, 0, 2, 2, 0, 0, -1, 0);
    expect_burst(2, 2, 2, 4, 0, 0, -1, 2);
    expect_burst(3, 0, 2, 2, 0, 0, -1, 0);
    expect_burst(0, 1, 2, 3, 0, 0, -1, 1);
    for (int i = 0; i < 60 && rep_seen == base; i++) tick();
    push_beats(0, 64'h43, 2);
    wait_done("rr_done", 200);
    // last is now 0, so requester 1 beats requester 3.
    t = cyc;
    push_beats(3, 64'h6, 1);
    push_beats(1, 64'h8, 1);
    expect_burst(1, 0, 1, 2, 0, 0, t, 0);
    expect_burst(3, 0, 1, 2, 0, 0, -1, 0);
    wait_done("rr_last_done", 60);

    // Burst cap: 20 nibbles queued, 15 granted, then re-granted for 5.
    t = cyc;
    for (int i = 0; i < 20; i++) beat_q[2].push_back(4'(i));
    expect_burst(2, 0, 15, 2, 0, 0, t, 0);
    expect_burst(2, 0, 5, 2, 0, 0, -1, 0);
    wait_done("cap_done", 200);

    // Zero hits: report exactly at E+2.
    cfg_write(3, 9);
    t = cyc;
    push_beats(3, 64'h321, 3);
    expect_burst(3, 0, 3, 2, 9, 0, t, 0);
    wait_done("zero_done", 60);

    // Config bypass at grant, mid-burst write affects only the next burst.
    t = cyc;
    cfg_we  = 1'b1;
    cfg_id  = 2'd1;
    cfg_seq = 4'd7;
    push_beats(1, 64'h7177, 4);
    expect_burst(1, 3, 4, 5, 7, 0, t, 3);
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 20 && !gnt[1]; i++) tick();
    chk("bypass_gnt_seen", gnt[1], 1);
    cfg_write(1, 2);
    wait_done("bypass_done", 60);
    t = cyc;
    push_beats(1, 64'h2, 1);
    expect_burst(1, 1, 1, 3, 2, 0, t, 1);
    wait_done("newseq_done", 60);

    // Hit pulse while idle sets the sticky error.
    chk("err_before_pulse", err, 0);
    pulse_req++;
    tick();
    tick();
    chk("err_idle_hit", err, 1);
    chk("busy_after_pulse", busy, 0);
    do_reset();
    chk("err_cleared", err, 0);

    // 15 hits: saturates the count without timing out.
    t = cyc;
    push_beats(0, 64'h4, 1);
    expect_burst(0, 15, 1, 17, 0, 0, t, 15);
    wait_done("k15_done", 80);
    chk("err_after_k15", err, 0);

    // Hit stuck for the full timeout window.
    t = cyc;
    push_beats(0, 64'h4, 1);
    expect_burst(0, 15, 1, 17, 0, 1, t, 16);
    wait_done("timeout_done", 80);
    chk("err_after_timeout", err, 1);

    // Reset mid-stream: outputs clear at once, no report follows.
    base = rep_seen;
    push_beats(2, 64'h87654321, 8);
    for (int i = 0; i < 20 && !gnt[2]; i++) tick();
    chk("rst_gnt_seen", gnt[2], 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", {gnt, m_valid, m_num, m_seq, res_valid, res_id, res_cnt, busy, err}, 0);
    chk("rst_err", err, 0);
    beat_q[2].delete();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    chk("no_res_after_reset", rep_seen - base, 0);
    chk("idle_after_reset", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_sched.md
# match_sched

Round-robin scheduler that shares one nibble pattern-match counter among four requesters. It grants one requester at a time and primes the matcher. It streams the requester's nibbles and pattern into the matcher, then drains the matcher's hit pulses. Finally it reports the per-burst match count tagged with the requester ID. It sits between the requester front-ends and the single match counter instance.

## Interface
- MAX_BURST, 15, max nibbles per grant; legal range 1..15.
- DRAIN_TIMEOUT, 16, max DRAIN cycles before error.

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  4  per-requester request; held high while data remains
- req_num  in  16  nibble of requester i on bits [4i+3:4i]
- gnt  out  4  one-hot; a beat of requester i is consumed each cycle gnt[i]&req[i]
- cfg_we  in  1  pattern register write strobe
- cfg_id  in  2  pattern register index
- cfg_seq  in  4  pattern value
- m_valid  out  1  matcher valid
- m_num  out  4  matcher nibble
- m_seq  out  4  matcher pattern, registered
- m_hit  in  1  matcher hit; one cycle per match, contiguous, starting the cycle after m_valid falls
- res_valid  out  1  one-cycle result strobe
- res_id  out  2  requester served
- res_cnt  out  4  hits counted, saturating at 15
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag; cleared only by reset

## Operation
- The four pattern registers reset to 0. cfg_we writes cfg_seq into reg[cfg_id] at any time.
- Round-robin pointer last:
  - Resets to 3, so requester 0 has first priority.
  - The winner is the first set req bit searching last+1, last+2, … with wraparound.
  - last is updated to the winner at grant.
- IDLE:
  - All outputs are 0.
  - If any req bit is set: latch the winner w and m_seq <= reg[w], then go to PRIME.
  - Same-cycle cfg write to w bypasses: the new value is used.
- PRIME (1 cycle): m_valid=1, m_num=0, gnt=0. Next state is STREAM; beat counter bc=0.
- STREAM:
  - If req[w] and bc<MAX_BURST: gnt[w]=1, m_valid=1, m_num=req_num[w], bc++.
  - Otherwise, in the end cycle E: gnt=0, m_valid=0, m_num=0, and go to DRAIN.
  - m_valid and m_num are combinational from req and req_num in STREAM only.
- DRAIN:
  - Clear hit count hc at entry.
  - Each cycle m_hit=1: hc increments, saturating at 15.
  - The first cycle with m_hit=0 goes to REPORT.
  - If DRAIN_TIMEOUT cycles elapse with m_hit still 1: set err, hc=15, go to REPORT.
- REPORT (1 cycle): res_valid=1, res_id=w, res_cnt=hc. Go to IDLE.
  - res_id and res_cnt hold until the next REPORT.
- m_hit=1 in IDLE, PRIME or STREAM sets err. The scheduler otherwise ignores the hit.
- m_seq stays stable from PRIME through REPORT. A cfg write to reg[w] mid-burst affects only later bursts.

## Timing
- All outputs are 0 during reset and immediately on reset assertion, including err, res_* and m_seq.
- Reset mid-burst abandons the burst with no REPORT. The matcher must be reset alongside.
- Latency, with req rising at cycle t in IDLE:
  - PRIME at t+1.
  - First gnt at t+2.
  - With n beats, E = t+2+n.
  - Hits at E+1..E+k.
  - DRAIN ends at E+k+1.
  - res_valid at E+k+2.
- If k=0, REPORT is at E+2.
- Minimum grant-to-grant spacing is n+5 cycles (k=0).
- A requester dropping req after PRIME gives n=0 and res_cnt=0.
- MAX_BURST cap: gnt falls after the 15th beat even if req is still high. The requester re-competes in round-robin order.

## Test plan
- Reset: set reg0=5. req[0] streams 5,3,5,5 and then drops. Matcher returns 3 hits. Expect gnt[0] for 4 cycles, m_seq=5, res_valid with res_id=0, res_cnt=3 at E+5.
- Round-robin: req=4'b1111 held, each burst 2 beats. Grants go 0,1,2,3,0 in that order, with last=0 after the fifth grant.
- Cap: req[2] held with 20 beats queued and MAX_BURST=15. Expect exactly 15 gnt cycles, then REPORT. If req[2] is alone, it is re-granted next.
- Zero hits: pattern 9, stream 1,2,3. Expect res_cnt=0 with res_valid exactly at E+2.
- Faults:
  - m_hit pulsed in IDLE sets err.
  - m_hit stuck high in DRAIN for 16 cycles gives err=1 and res_cnt=15.
  - Assert reset_n mid-STREAM: all outputs go to 0 immediately, err is cleared, and no res_valid occurs.
- Config bypass: cfg_we to id 1 with value 7 in the same cycle req[1] wins. m_seq=7 at PRIME. A write of 2 to id 1 during STREAM leaves m_seq=7.
